// File: rtl/sram_pkg.sv
// Shared types for the two-port SRAM strobe controller.
package sram_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef logic port_id_t;
endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; the history bit is owned by the caller.
module rr_arb2
  import sram_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  port_id_t last,
  output port_id_t gnt_id,
  output logic     gnt_valid
);

  always_comb begin
    gnt_valid = req0 | req1;
    // on a tie the port not served last wins; otherwise the lone requester
    if (req0 && req1) gnt_id = ~last;
    else              gnt_id = req1;
  end

endmodule

// File: rtl/sram_arb2.sv
// Serialises two requesters onto the async SRAM: SETUP / STROBE / HOLD per access.
module sram_arb2
  import sram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd_n,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  state_t   state;
  port_id_t last, gid, gnt_id;
  logic     gnt_valid, we_r;

  rr_arb2 u_arb (
    .req0      (req0),
    .req1      (req1),
    .last      (last),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Every pin is a flop so nothing combinational reaches the SRAM or requesters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      gid       <= 1'b0;
      we_r      <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_cs   <= 1'b0;
      sram_wr   <= 1'b0;
      sram_rd_n <= 1'b1;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: if (gnt_valid) begin
          state     <= SETUP;
          last      <= gnt_id;
          gid       <= gnt_id;
          we_r      <= gnt_id ? we1    : we0;
          sram_addr <= gnt_id ? addr1  : addr0;
          sram_din  <= gnt_id ? wdata1 : wdata0;
          sram_cs   <= 1'b1;
          busy      <= 1'b1;
        end
        SETUP: begin
          state     <= STROBE;
          sram_wr   <= we_r;
          sram_rd_n <= we_r;
        end
        STROBE: begin
          // write data was latched on the wr rising edge; read data is valid now
          state     <= HOLD;
          sram_wr   <= 1'b0;
          sram_rd_n <= 1'b1;
          if (!we_r) rdata <= sram_dout;
          ack0      <= ~gid;
          ack1      <= gid;
        end
        HOLD: begin
          state   <= IDLE;
          sram_cs <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arb2.md
# sram_arb2

Two-port round-robin controller for the 256x8 asynchronous SRAM macro. Two synchronous requesters (e.g. CPU-side and DMA-side) issue single-byte read or write transactions. The block serialises them and converts each into the SRAM's strobe protocol: chip select, write latched on `sram_wr` rising edge, read driven while `sram_rd_n` is low. It sits directly between the requesters and the SRAM pins; it is the only driver of those pins.

## Interface
- `AW`, 8, address width (SRAM depth 2^AW)
- `DW`, 8, data width
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0` / `req1`  in  1  request; held high until matching `ack`
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` high
- `addr0` / `addr1`  in  AW  byte address; stable while `req` high
- `wdata0` / `wdata1`  in  DW  write data; stable while `req` high
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata`  out  DW  read data; valid in the `ack` cycle of a read
- `busy`  out  1  high in every state except IDLE
- `sram_cs`  out  1  chip select, active high
- `sram_wr`  out  1  write strobe; SRAM latches on its rising edge
- `sram_rd_n`  out  1  read enable, active low
- `sram_addr`  out  AW  SRAM address
- `sram_din`  out  DW  SRAM write data
- `sram_dout`  in  DW  SRAM read data; tri-stated when `sram_cs`=0

## Operation
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. Each state lasts exactly one cycle except IDLE.
- IDLE: if any `req` is high at a clock edge, grant and go to SETUP. On grant, register the port id, `we`, `addr` and `wdata`. The SRAM pins are driven only from these registers.
- Arbitration: with a single request, that port wins. With both requesting, the port not granted last wins. The `last` pointer resets to 1, so port 0 wins the first tie. `last` updates only on grant.
- SETUP: `sram_cs`=1, address and data driven, `sram_wr`=0, `sram_rd_n`=1.
- STROBE: for a write, `sram_wr`=1. For a read, `sram_rd_n`=0. The read path samples `sram_dout` into `rdata` at the STROBE->HOLD edge.
- HOLD: `sram_wr`=0, `sram_rd_n`=1, `sram_cs`=1, address and data still held. `ack` of the granted port is high for this one cycle.
- The requester must drop or change `req` at the HOLD->IDLE edge. A `req` still high in IDLE is treated as a new transaction.
- `rdata` holds its last read value until the next read capture. Writes do not alter it.
- Reset values: `ack0`=`ack1`=0, `busy`=0, `sram_cs`=0, `sram_wr`=0, `sram_rd_n`=1, `sram_addr`=0, `sram_din`=0, `rdata`=0, state=IDLE, `last`=1.
- Reset mid-transaction: all outputs return to reset values immediately and asynchronously, and no `ack` is issued.
  - If reset hits in STROBE of a write, the SRAM may already have latched the data. The requester must reissue the write.
  - The falling `sram_wr` edge caused by reset is harmless.

## Timing
- Latency from the `req` sampling edge to `ack`: 3 cycles (ack during HOLD, the third cycle after grant).
- Throughput: one transaction per 4 cycles, because IDLE costs one cycle between transactions.
- `sram_addr`/`sram_din` are stable one full cycle before and one full cycle after the `sram_wr` rising edge. This meets the SRAM's setup and hold requirements.
- All outputs are registered; no combinational path runs from inputs to outputs.
- A port that loses arbitration keeps `req` high and is served next. Maximum wait with both ports saturated: 4 cycles.

## Structure
- Shared package `sram_pkg`: `AW`/`DW` defaults, state enum (IDLE, SETUP, STROBE, HOLD), 1-bit port-id type.
- Sub-module `rr_arb2`: combinational two-request round-robin pick (`req0`, `req1`, `last` -> `gnt_id`, `gnt_valid`). The `last` register lives in the parent.

## Test plan
- Single write from port 0 (`addr0`=8'h3C, `wdata0`=8'hA5):
  - `sram_wr` rises exactly once, with `sram_addr`=8'h3C and `sram_din`=8'hA5 stable SETUP through HOLD.
  - `ack0` pulses 3 cycles after grant.
- Write then read from port 1 (addr 8'h10, data 8'h5A), with the SRAM behavioural model:
  - The read `ack1` cycle shows `rdata`=8'h5A.
  - `sram_rd_n` is low for exactly one cycle.
- Both ports request continuously from reset:
  - Grants go 0,1,0,1.
  - Acks are spaced 4 cycles apart.
  - Neither port waits more than 4 cycles.
- Port 0 requests alone 3 times back-to-back:
  - 3 grants to port 0, no idle starvation.
  - `last` stays 0, so a later tie goes to port 1.
- `rst_n` asserted during STROBE of a read:
  - Outputs immediately go `sram_cs`=0, `sram_rd_n`=1, `busy`=0.
  - No `ack`.
  - After release, the same request completes normally.
- Read with `sram_cs`=0 phases: the model drives Z while idle, and `rdata` keeps its previous value (8'h5A) across idle and write cycles.
